dsp48_a1: RTL and testbench
===========================

DSP48_A1 -- requirements
Module: dsp48_a1

Interface
REQ-001 Parameters, each SHALL be 1 = registered stage, 0 = combinational bypass: A0REG=0, A1REG=1, B0REG=0, B1REG=1, CREG=1, DREG=1, MREG=1, PREG=1, CARRYINREG=1, CARRYOUTREG=1, OPMODEREG=1.
REQ-002 Parameter CARRYINSEL="OPMODE5": carry-in source; "OPMODE5" or "CARRYIN".
REQ-003 Parameter B_INPUT="DIRECT": B source; "DIRECT" selects B, "CASCADE" selects BCIN.
REQ-004 One clock; reset is synchronous and active-low. Ports:
- CLK in 1: clock; all registers on the rising edge.
- RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE in 1 each: synchronous active-low resets of the matching registers.
- A in 18, B in 18, D in 18: multiplier/pre-adder operands.
- C in 48: post-adder operand.
- BCIN in 18: cascaded B input.
- PCIN in 48: cascaded P input.
- CARRYIN in 1: external carry.
- OPMODE in 8: operation select.
- CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE in 1 each: clock enables.
- M out 36: multiplier result.
- P out 48: post-adder result.
- PCOUT out 48: copy of P.
- BCOUT out 18: B1-stage output.
- CARRYOUT out 1: post-adder carry.
- CARRYOUTF out 1: copy of CARRYOUT.

Function
REQ-005 Each register stage SHALL load on a rising edge when its CE=1, hold when CE=0; its reset SHALL take priority over CE and clear the stage to 0.
REQ-006 Stage/CE/reset mapping: A0, A1 (CEA, RSTA); B0, B1 (CEB, RSTB); C (CEC, RSTC); D (CED, RSTD); M (CEM, RSTM); P (CEP, RSTP); CYI, CYO (CECARRYIN, RSTCARRYIN); OPMODE (CEOPMODE, RSTOPMODE).
REQ-007 B0 input SHALL be B or BCIN per B_INPUT; A0 input SHALL be A.
REQ-008 Pre-adder (18-bit, wrap) SHALL compute D_reg − B0 if OPMODE[6]=1, else D_reg + B0.
REQ-009 B1 input SHALL be the pre-adder result if OPMODE[4]=1, else B0; BCOUT SHALL equal the B1 output; A1 input SHALL be the A0 output.
REQ-010 Multiplier SHALL compute B1 × A1 (unsigned, 36-bit), feed the M stage, and M SHALL equal the M-stage output.
REQ-011 X mux OPMODE[1:0]:
- 00 = 0
- 01 = zero-extended M
- 10 = P
- 11 = {D_reg[11:0], A1, B1}
REQ-012 Z mux OPMODE[3:2]:
- 00 = 0
- 01 = PCIN
- 10 = P
- 11 = C_reg
REQ-013 Carry-in SHALL be OPMODE[5] when CARRYINSEL="OPMODE5", CARRYIN when "CARRYIN", registered in CYI.
REQ-014 Post-adder SHALL compute 49-bit {cout, sum} = Z + X + CYI if OPMODE[7]=0, else Z − (X + CYI) mod 2^49, with bit 48 as borrow.
- sum feeds the P stage.
- cout feeds the CYO stage.
REQ-015 Outputs SHALL be driven as follows: PCOUT = P; CARRYOUT = CYO output; CARRYOUTF = CARRYOUT.
REQ-016 OPMODE controls SHALL come from the OPMODE stage output.
REQ-017 Latency with default parameters:
- BCOUT: 2 cycles after D/B.
- M: 3 cycles.
- P and CARRYOUT: 4 cycles.
REQ-018 An invalid string parameter SHALL default to "OPMODE5" or "DIRECT" respectively.

Reset
REQ-019 With all RST* = 0 at a rising edge, M, P, PCOUT, BCOUT, CARRYOUT and CARRYOUTF SHALL all be 0 after that edge, regardless of CE values.
REQ-020 Reset asserted mid-operation SHALL clear only its own stages; other stages continue.

Structure
REQ-021 A shared package SHALL hold:
- OPMODE bit-index constants.
- X/Z select encodings.
- Width constants (18, 36, 48).
REQ-022 One sub-module dsp_reg_stage (params WIDTH, REG) SHALL implement the register-or-bypass stage with CE and sync active-low reset, instantiated per stage.

Verification
REQ-023 All RST*=0, random inputs/CEs, one edge -> M, P, PCOUT, BCOUT, CARRYOUT, CARRYOUTF = 0.
REQ-024 Path 1, OPMODE=0xDD, A=20, B=10, C=350, D=25, CEs=1, 4 cycles -> BCOUT=0xF, M=0x12C, P=PCOUT=0x32, CARRYOUT=CARRYOUTF=0.
REQ-025 Path 2, OPMODE=0x10, same operands, 3 more cycles -> BCOUT=0x23, M=0x2BC, P=PCOUT=0, CARRYOUT=0.
REQ-026 Path 3, OPMODE=0x0A, same operands, 3 cycles -> BCOUT=0xA, M=0xC8, P=PCOUT, CARRYOUT=CARRYOUTF.
REQ-027 Path 4, OPMODE=0xA7, A=5, B=6, D=25, PCIN=3000, 3 cycles -> BCOUT=6, M=0x1E, P=PCOUT=0xFE6FFFEC0BB1, CARRYOUT=CARRYOUTF=1.
REQ-028 CE hold, CEP=0 with new operands -> P unchanged; then CEP=1 -> P updates next edge.

Source files
------------

// File: rtl/dsp48_a1_pkg.sv
// Shared constants for the DSP48A1 slice: datapath widths, OPMODE bit positions
// and the X/Z post-adder multiplexer select encodings.
package dsp48_a1_pkg;

    localparam int AW = 18;   // A/B/D operand width
    localparam int MW = 36;   // multiplier product width
    localparam int PW = 48;   // post-adder / P width

    // OPMODE bit positions
    localparam int OPM_X_LO    = 0;
    localparam int OPM_Z_LO    = 2;
    localparam int OPM_PRE_EN  = 4;
    localparam int OPM_CIN     = 5;
    localparam int OPM_PRE_SUB = 6;
    localparam int OPM_POST_SUB = 7;

    // X multiplexer selects
    localparam logic [1:0] XSEL_ZERO = 2'b00;
    localparam logic [1:0] XSEL_M    = 2'b01;
    localparam logic [1:0] XSEL_P    = 2'b10;
    localparam logic [1:0] XSEL_DAB  = 2'b11;

    // Z multiplexer selects
    localparam logic [1:0] ZSEL_ZERO = 2'b00;
    localparam logic [1:0] ZSEL_PCIN = 2'b01;
    localparam logic [1:0] ZSEL_P    = 2'b10;
    localparam logic [1:0] ZSEL_C    = 2'b11;

endpackage

// File: rtl/dsp48_a1_reg_stage.sv
// Register-or-bypass pipeline stage with clock enable and synchronous
// active-low reset. REG=0 turns the stage into a plain wire.
module dsp_reg_stage #(
    parameter int WIDTH = 18,
    parameter int REG   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (REG == 1) begin : g_reg
            logic [WIDTH-1:0] r;
            // reset wins over enable; enable gates the load
            always_ff @(posedge clk) begin
                if (!rst_n)  r <= '0;
                else if (ce) r <= d;
            end
            assign q = r;
        end else begin : g_byp
            // control pins are meaningless when the stage is bypassed
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst_n ^ ce;
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp48_a1.sv
// DSP48A1-style slice: optional pre-adder, 18x18 unsigned multiplier and
// 48-bit post-adder/subtracter with configurable pipeline registers.
module dsp48_a1
    import dsp48_a1_pkg::*;
#(
    parameter int    A0REG       = 0,
    parameter int    A1REG       = 1,
    parameter int    B0REG       = 0,
    parameter int    B1REG       = 1,
    parameter int    CREG        = 1,
    parameter int    DREG        = 1,
    parameter int    MREG        = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    CARRYOUTREG = 1,
    parameter int    OPMODEREG   = 1,
    parameter string CARRYINSEL  = "OPMODE5",
    parameter string B_INPUT     = "DIRECT"
) (
    input  logic          CLK,
    input  logic          RSTA,
    input  logic          RSTB,
    input  logic          RSTC,
    input  logic          RSTD,
    input  logic          RSTM,
    input  logic          RSTP,
    input  logic          RSTCARRYIN,
    input  logic          RSTOPMODE,
    input  logic [17:0]   A,
    input  logic [17:0]   B,
    input  logic [17:0]   D,
    input  logic [47:0]   C,
    input  logic [17:0]   BCIN,
    input  logic [47:0]   PCIN,
    input  logic          CARRYIN,
    input  logic [7:0]    OPMODE,
    input  logic          CEA,
    input  logic          CEB,
    input  logic          CEC,
    input  logic          CED,
    input  logic          CEM,
    input  logic          CEP,
    input  logic          CECARRYIN,
    input  logic          CEOPMODE,
    output logic [35:0]   M,
    output logic [47:0]   P,
    output logic [47:0]   PCOUT,
    output logic [17:0]   BCOUT,
    output logic          CARRYOUT,
    output logic          CARRYOUTF
);

    // anything other than the alternate string falls back to the default source
    localparam bit CIN_EXT = (CARRYINSEL == "CARRYIN");
    localparam bit B_CASC  = (B_INPUT == "CASCADE");

    logic [7:0]    opm;
    logic [AW-1:0] d_r, a0, a1, b0, b1, b0_in, b1_in, preadd;
    logic [PW-1:0] c_r, x_mux, z_mux, p_r;
    logic [MW-1:0] mult, m_r;
    logic          cyi_in, cyi, cyo;
    logic [PW:0]   post;

    dsp_reg_stage #(.WIDTH(8),  .REG(OPMODEREG)) u_opm (.clk(CLK), .rst_n(RSTOPMODE), .ce(CEOPMODE), .d(OPMODE), .q(opm));
    dsp_reg_stage #(.WIDTH(AW), .REG(DREG))      u_d   (.clk(CLK), .rst_n(RSTD), .ce(CED), .d(D), .q(d_r));
    dsp_reg_stage #(.WIDTH(PW), .REG(CREG))      u_c   (.clk(CLK), .rst_n(RSTC), .ce(CEC), .d(C), .q(c_r));
    dsp_reg_stage #(.WIDTH(AW), .REG(A0REG))     u_a0  (.clk(CLK), .rst_n(RSTA), .ce(CEA), .d(A), .q(a0));
    dsp_reg_stage #(.WIDTH(AW), .REG(A1REG))     u_a1  (.clk(CLK), .rst_n(RSTA), .ce(CEA), .d(a0), .q(a1));

    assign b0_in  = B_CASC ? BCIN : B;
    dsp_reg_stage #(.WIDTH(AW), .REG(B0REG))     u_b0  (.clk(CLK), .rst_n(RSTB), .ce(CEB), .d(b0_in), .q(b0));

    // pre-adder wraps at 18 bits
    assign preadd = opm[OPM_PRE_SUB] ? (d_r - b0) : (d_r + b0);
    assign b1_in  = opm[OPM_PRE_EN] ? preadd : b0;
    dsp_reg_stage #(.WIDTH(AW), .REG(B1REG))     u_b1  (.clk(CLK), .rst_n(RSTB), .ce(CEB), .d(b1_in), .q(b1));

    assign mult = {{(MW-AW){1'b0}}, b1} * {{(MW-AW){1'b0}}, a1};
    dsp_reg_stage #(.WIDTH(MW), .REG(MREG))      u_m   (.clk(CLK), .rst_n(RSTM), .ce(CEM), .d(mult), .q(m_r));

    assign cyi_in = CIN_EXT ? CARRYIN : opm[OPM_CIN];
    dsp_reg_stage #(.WIDTH(1),  .REG(CARRYINREG)) u_cyi (.clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .d(cyi_in), .q(cyi));

    // X operand select
    always_comb begin
        x_mux = '0;
        case (opm[OPM_X_LO +: 2])
            XSEL_ZERO: x_mux = '0;
            XSEL_M:    x_mux = {{(PW-MW){1'b0}}, m_r};
            XSEL_P:    x_mux = p_r;
            XSEL_DAB:  x_mux = {d_r[11:0], a1, b1};
            default:   x_mux = '0;
        endcase
    end

    // Z operand select
    always_comb begin
        z_mux = '0;
        case (opm[OPM_Z_LO +: 2])
            ZSEL_ZERO: z_mux = '0;
            ZSEL_PCIN: z_mux = PCIN;
            ZSEL_P:    z_mux = p_r;
            ZSEL_C:    z_mux = c_r;
            default:   z_mux = '0;
        endcase
    end

    // 49-bit post-adder; in subtract mode bit 48 is the borrow
    assign post = opm[OPM_POST_SUB]
                ? ({1'b0, z_mux} - ({1'b0, x_mux} + {{PW{1'b0}}, cyi}))
                : ({1'b0, z_mux} + {1'b0, x_mux} + {{PW{1'b0}}, cyi});

    dsp_reg_stage #(.WIDTH(PW), .REG(PREG))        u_p   (.clk(CLK), .rst_n(RSTP), .ce(CEP), .d(post[PW-1:0]), .q(p_r));
    dsp_reg_stage #(.WIDTH(1),  .REG(CARRYOUTREG)) u_cyo (.clk(CLK), .rst_n(RSTCARRYIN), .ce(CECARRYIN), .d(post[PW]), .q(cyo));

    assign M         = m_r;
    assign P         = p_r;
    assign PCOUT     = p_r;
    assign BCOUT     = b1;
    assign CARRYOUT  = cyo;
    assign CARRYOUTF = cyo;

endmodule

// File: tb/tb_dsp48_a1.sv
// Self-checking bench for dsp48_a1 (default parameters): reset, directed path
// vectors, randomized steady-state checks against an arithmetic model,
// per-stage reset and P clock-enable hold.
module tb_dsp48_a1;

    logic        CLK = 1'b0;
    logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE;
    logic [17:0] A, B, D, BCIN;
    logic [47:0] C, PCIN;
    logic        CARRYIN;
    logic [7:0]  OPMODE;
    logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE;
    logic [35:0] M;
    logic [47:0] P, PCOUT;
    logic [17:0] BCOUT;
    logic        CARRYOUT, CARRYOUTF;

    int pass_cnt = 0;
    int total    = 0;

    dsp48_a1 dut (
        .CLK(CLK), .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM),
        .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
        .A(A), .B(B), .D(D), .C(C), .BCIN(BCIN), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .OPMODE(OPMODE), .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM),
        .CEP(CEP), .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
        .M(M), .P(P), .PCOUT(PCOUT), .BCOUT(BCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  op;
        logic [17:0] a, b, d;
        logic [47:0] c, pcin;
        int          cyc;
        logic [17:0] e_bc;
        logic [35:0] e_m;
        logic [47:0] e_p;
        logic        e_co;
    } vec_t;

    vec_t vt [4];

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // advance n rising edges, land 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_rst(input logic v);
        RSTA = v; RSTB = v; RSTC = v; RSTD = v; RSTM = v; RSTP = v; RSTCARRYIN = v; RSTOPMODE = v;
    endtask

    task automatic set_ce(input logic v);
        CEA = v; CEB = v; CEC = v; CED = v; CEM = v; CEP = v; CECARRYIN = v; CEOPMODE = v;
    endtask

    task automatic chk_all(input string tag, input logic [17:0] bc, input logic [35:0] m,
                           input logic [47:0] p, input logic co);
        chk({tag, " BCOUT"},     {30'b0, BCOUT}, {30'b0, bc});
        chk({tag, " M"},         {12'b0, M}, {12'b0, m});
        chk({tag, " P"},         P, p);
        chk({tag, " PCOUT"},     PCOUT, p);
        chk({tag, " CARRYOUT"},  {47'b0, CARRYOUT}, {47'b0, co});
        chk({tag, " CARRYOUTF"}, {47'b0, CARRYOUTF}, {47'b0, co});
    endtask

    initial begin
        logic [17:0] mb_bc;
        logic [35:0] mb_m;
        logic [48:0] mb_full;
        logic [47:0] mx, mz, p_hold;
        int xs, zs;

        vt[0] = '{8'hDD, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0,    4, 18'h0F, 36'h12C, 48'h32,           1'b0};
        vt[1] = '{8'h10, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0,    3, 18'h23, 36'h2BC, 48'h0,            1'b0};
        vt[2] = '{8'h0A, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0,    3, 18'h0A, 36'hC8,  48'h0,            1'b0};
        vt[3] = '{8'hA7, 18'd5,  18'd6,  18'd25, 48'd350, 48'd3000, 3, 18'h06, 36'h1E,  48'hFE6FFFEC0BB1, 1'b1};

        // all resets with random operands and enables: outputs must clear
        set_rst(1'b1);
        A = 18'($urandom); B = 18'($urandom); D = 18'($urandom); BCIN = 18'($urandom);
        C = {16'($urandom), 32'($urandom)}; PCIN = {16'($urandom), 32'($urandom)};
        CARRYIN = 1'($urandom); OPMODE = 8'($urandom);
        set_ce(1'b1);
        step(3);
        set_rst(1'b0);
        {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = 8'($urandom);
        step(1);
        chk_all("reset", 18'd0, 36'd0, 48'd0, 1'b0);

        // directed paths, applied back to back from the cleared state
        set_rst(1'b1);
        set_ce(1'b1);
        BCIN = '0; CARRYIN = 1'b0;
        for (int i = 0; i < 4; i++) begin
            OPMODE = vt[i].op; A = vt[i].a; B = vt[i].b; D = vt[i].d;
            C = vt[i].c; PCIN = vt[i].pcin;
            step(vt[i].cyc);
            chk_all($sformatf("path%0d", i + 1), vt[i].e_bc, vt[i].e_m, vt[i].e_p, vt[i].e_co);
        end

        // random operands held to steady state, X/Z never select P feedback
        for (int n = 0; n < 20; n++) begin
            xs = $urandom_range(0, 2); if (xs == 2) xs = 3;
            zs = $urandom_range(0, 2); if (zs == 2) zs = 3;
            OPMODE = {4'($urandom), 2'(zs), 2'(xs)};
            A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
            C = {16'($urandom), 32'($urandom)}; PCIN = {16'($urandom), 32'($urandom)};
            BCIN = 18'($urandom); CARRYIN = 1'($urandom);
            step(5);

            if (OPMODE[4]) mb_bc = OPMODE[6] ? 18'(D - B) : 18'(D + B);
            else           mb_bc = B;
            mb_m = 36'(mb_bc) * 36'(A);
            case (xs)
                0:       mx = 48'd0;
                1:       mx = 48'(mb_m);
                default: mx = (48'(D[11:0]) << 36) + (48'(A) << 18) + 48'(mb_bc);
            endcase
            case (zs)
                0:       mz = 48'd0;
                1:       mz = PCIN;
                default: mz = C;
            endcase
            if (OPMODE[7]) mb_full = 49'(mz) - (49'(mx) + 49'(OPMODE[5]));
            else           mb_full = 49'(mz) + 49'(mx) + 49'(OPMODE[5]);
            chk_all($sformatf("rand%0d", n), mb_bc, mb_m, mb_full[47:0], mb_full[48]);
        end

        // M-stage reset clears M only; BCOUT keeps its value
        RSTM = 1'b0;
        step(1);
        chk("rstm M", {12'b0, M}, 48'd0);
        chk("rstm BCOUT", {30'b0, BCOUT}, {30'b0, mb_bc});
        RSTM = 1'b1;
        step(1);
        chk("rstm recover M", {12'b0, M}, {12'b0, mb_m});

        // P clock-enable hold: P follows C, then freezes while CEP=0
        OPMODE = 8'h0C; C = 48'd111;
        step(3);
        chk("cep load", P, 48'd111);
        p_hold = P;
        CEP = 1'b0; C = 48'd222;
        step(3);
        chk("cep hold", P, 48'd111);
        CEP = 1'b1;
        step(1);
        chk("cep resume", P, 48'd222);
        if (p_hold == 48'd222) $display("FAIL cep pre-hold: got %h expected %h", p_hold, 48'd111);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    // hard stop so a stuck run still reports
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
